cdc_status_monitor: RTL and testbench
=====================================

// Module: cdc_status_monitor
// PURPOSE
//  Status stage directly downstream of the 8-bit two-flop CDC, in the slow (clk_1) domain.
//  A multi-bit 2FF sync can present torn intermediate codes for a cycle; this block commits a
//  value only after it is stable for STABLE_CYCLES consecutive cycles. It also exports the
//  committed status, a change-event handshake, a saturating change counter and a hysteresis alarm.
// PARAMETERS
//  DATA_W         8   width of synchronized data / status
//  STABLE_CYCLES  3   consecutive equal samples required to commit (legal range >= 2)
//  CNT_W          16  width of change counter
// PORTS
//  clk_1_i         in   1       slow-domain clock; single clock, all logic posedge
//  rst_ni          in   1       synchronous active-low reset, sampled on posedge clk_1_i
//  data_i          in   DATA_W  output of the 2FF CDC (already in clk_1 domain)
//  thr_hi_i        in   DATA_W  alarm set threshold (quasi-static)
//  thr_lo_i        in   DATA_W  alarm clear threshold (quasi-static, thr_lo_i < thr_hi_i)
//  clr_i           in   1       clear chg_cnt_o and ovf_o
//  status_o        out  DATA_W  last committed (stable) value
//  status_valid_o  out  1       high once the first value is committed
//  evt_valid_o     out  1       change event pending
//  evt_data_o      out  DATA_W  new value of the pending change event
//  evt_ready_i     in   1       consumer accepts the event
//  chg_cnt_o       out  CNT_W   number of committed changes, saturating
//  ovf_o           out  1       sticky: an unaccepted event was overwritten
//  alarm_o         out  1       hysteresis alarm on status_o
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): every output 0, cand_q=0, cnt=0, state IDLE. Reset mid-settle drops the candidate.
//  FSM (filter): IDLE -> SETTLING unconditionally: cand_q<=data_i, cnt<=1.
//   SETTLING: data_i!=cand_q -> reload cand_q, cnt<=1; ==cand_q & cnt==STABLE_CYCLES-1 -> commit, STABLE;
//             ==cand_q otherwise -> cnt<=cnt+1.
//   STABLE:   data_i!=cand_q -> reload cand_q, cnt<=1, SETTLING; else hold.
//  Latency: data_i==X on cycles t..t+S-1 (S=STABLE_CYCLES, X differing at t) -> status_o==X from t+S.
//  Any glitch shorter than S cycles never reaches status_o; status_o holds the old value meanwhile.
//  Commit: status_o<=cand_q, status_valid_o<=1. A commit is a "change" iff status_valid_o was 1 and
//   cand_q!=status_o (re-commit of same value after a glitch is not a change). First commit is no change.
//  Change: chg_cnt_o+1 saturating at all-ones; event register loaded (evt_valid_o<=1, evt_data_o<=new).
//  Event handshake: transfer when evt_valid_o&evt_ready_i; evt_valid_o drops next cycle unless a new
//   change loads the same cycle (then stays 1 with new data, no overflow). Change while
//   evt_valid_o&!evt_ready_i -> overwrite with newest, ovf_o<=1. evt_data_o stable while unaccepted otherwise.
//  clr_i: chg_cnt_o<=0, ovf_o<=0; clr_i wins over a same-cycle increment/overflow.
//  Alarm (registered, 1 cycle after status_o): if !status_valid_o -> 0; status_o>=thr_hi_i -> 1;
//   status_o<=thr_lo_i -> 0; else hold. Unsigned compares.
// STRUCTURE
//  Package cdc_status_pkg: DATA_W default localparam, typedef enum logic [1:0] {IDLE,SETTLING,STABLE}
//   filt_state_e.
//  Sub-module cdc_stable_filter (FSM + cand_q + cnt; outputs commit pulse and value); top holds status,
//   event register, counter and alarm. Counter width for cnt = $clog2(STABLE_CYCLES+1).
// TESTING
//  1 Reset release, data_i=8'h00 const -> status_valid_o=1 after S+1 cycles, evt_valid_o=0, chg_cnt_o=0.
//  2 Stable 8'h00, then 8'h5A held -> status_o=8'h5A exactly 3 cycles after first 5A sample, evt 5A, cnt=1.
//  3 Torn code: 00 -> 1 cycle 8'h7F -> 00 -> status_o stays 00, no event, cnt unchanged.
//  4 Two changes 11 then 22 with evt_ready_i=0 -> evt_data_o=22, ovf_o=1; ready+change same cycle -> ovf_o stays 0.
//  5 thr_hi=C0, thr_lo=40: commit C0 -> alarm 1; 80 -> stays 1; 40 -> 0; reset mid-SETTLING -> all 0.
//  6 CNT_W=2: 4 changes -> chg_cnt_o=3 (sat); clr_i with a commit same cycle -> chg_cnt_o=0.

Source files
------------

// File: rtl/cdc_status_pkg.sv
// Shared types and defaults for the CDC status monitor.
// The filter state names are visible to both the top and its filter sub-module.
package cdc_status_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    STABLE
  } filt_state_e;

endpackage

// File: rtl/cdc_stable_filter.sv
// Stability filter: a sample is committed only after STABLE_CYCLES consecutive equal samples.
// commit_o is a single-cycle combinational pulse; commit_data_o carries the candidate being committed.
module cdc_stable_filter
  import cdc_status_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STABLE_CYCLES = 3
) (
  input  logic              clk_1_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  output logic              commit_o,
  output logic [DATA_W-1:0] commit_data_o
);

  localparam int CNT_BITS = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_CYCLES - 1);

  filt_state_e         state_q, state_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_1_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = SETTLING;
        cand_d  = data_i;
        cnt_d   = CNT_ONE;
      end
      SETTLING: begin
        if (data_i != cand_q) begin
          cand_d = data_i;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          // This sample is the STABLE_CYCLES-th equal one in a row.
          commit_o = 1'b1;
          state_d  = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE: begin
        if (data_i != cand_q) begin
          cand_d  = data_i;
          cnt_d   = CNT_ONE;
          state_d = SETTLING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit_data_o = cand_q;

endmodule

// File: rtl/cdc_status_monitor.sv
// Slow-domain status stage after an 8-bit 2FF sync: filtered status, change events with
// overwrite detection, saturating change counter and a hysteresis alarm.
module cdc_status_monitor
  import cdc_status_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 16
) (
  input  logic              clk_1_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] thr_hi_i,
  input  logic [DATA_W-1:0] thr_lo_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] status_o,
  output logic              status_valid_o,
  output logic              evt_valid_o,
  output logic [DATA_W-1:0] evt_data_o,
  input  logic              evt_ready_i,
  output logic [CNT_W-1:0]  chg_cnt_o,
  output logic              ovf_o,
  output logic              alarm_o
);

  logic              commit;
  logic [DATA_W-1:0] commit_data;
  logic              change;

  logic [DATA_W-1:0] status_q, status_d;
  logic              valid_q, valid_d;
  logic              evt_valid_q, evt_valid_d;
  logic [DATA_W-1:0] evt_data_q, evt_data_d;
  logic [CNT_W-1:0]  chg_cnt_q, chg_cnt_d;
  logic              ovf_q, ovf_d;
  logic              alarm_q, alarm_d;

  cdc_stable_filter #(
    .DATA_W       (DATA_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk_1_i      (clk_1_i),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .commit_o     (commit),
    .commit_data_o(commit_data)
  );

  // Re-committing the same value after a glitch, and the very first commit, are not changes.
  assign change = commit && valid_q && (commit_data != status_q);

  always_comb begin
    status_d    = status_q;
    valid_d     = valid_q;
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    chg_cnt_d   = chg_cnt_q;
    ovf_d       = ovf_q;
    alarm_d     = alarm_q;

    if (commit) begin
      status_d = commit_data;
      valid_d  = 1'b1;
    end

    if (change) begin
      evt_valid_d = 1'b1;
      evt_data_d  = commit_data;
      if (evt_valid_q && !evt_ready_i) ovf_d = 1'b1;
      if (chg_cnt_q != {CNT_W{1'b1}}) chg_cnt_d = chg_cnt_q + CNT_W'(1);
    end else if (evt_valid_q && evt_ready_i) begin
      evt_valid_d = 1'b0;
    end

    if (clr_i) begin
      chg_cnt_d = '0;
      ovf_d     = 1'b0;
    end

    // Alarm follows the registered status, so it lags status_o by one cycle.
    if (!valid_q)                 alarm_d = 1'b0;
    else if (status_q >= thr_hi_i) alarm_d = 1'b1;
    else if (status_q <= thr_lo_i) alarm_d = 1'b0;
  end

  always_ff @(posedge clk_1_i) begin
    if (!rst_ni) begin
      status_q    <= '0;
      valid_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      chg_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      status_q    <= status_d;
      valid_q     <= valid_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      chg_cnt_q   <= chg_cnt_d;
      ovf_q       <= ovf_d;
      alarm_q     <= alarm_d;
    end
  end

  assign status_o       = status_q;
  assign status_valid_o = valid_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_data_o     = evt_data_q;
  assign chg_cnt_o      = chg_cnt_q;
  assign ovf_o          = ovf_q;
  assign alarm_o        = alarm_q;

endmodule

// File: tb/tb_cdc_status_monitor.sv
// Bench for cdc_status_monitor: directed scenarios then randomized traffic, every cycle
// compared against a run-length based reference model of the status monitor.
module tb_cdc_status_monitor;

  localparam int DATA_W = 8;
  localparam int S      = 3;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] thr_hi;
  logic [DATA_W-1:0] thr_lo;
  logic              clr;
  logic              ready;
  logic [DATA_W-1:0] status;
  logic              status_valid;
  logic              evt_valid;
  logic [DATA_W-1:0] evt_data;
  logic [CNT_W-1:0]  chg_cnt;
  logic              ovf;
  logic              alarm;

  always #5 clk = ~clk;

  cdc_status_monitor #(
    .DATA_W       (DATA_W),
    .STABLE_CYCLES(S),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_1_i       (clk),
    .rst_ni        (rst_n),
    .data_i        (data),
    .thr_hi_i      (thr_hi),
    .thr_lo_i      (thr_lo),
    .clr_i         (clr),
    .status_o      (status),
    .status_valid_o(status_valid),
    .evt_valid_o   (evt_valid),
    .evt_data_o    (evt_data),
    .evt_ready_i   (ready),
    .chg_cnt_o     (chg_cnt),
    .ovf_o         (ovf),
    .alarm_o       (alarm)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: run = how many identical samples in a row since reset or last change.
  int        run = 0;
  logic [7:0] last_smp = '0;
  logic [7:0] m_status = '0;
  logic       m_valid = 1'b0;
  logic       m_evt_valid = 1'b0;
  logic [7:0] m_evt_data = '0;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       m_alarm = 1'b0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge();
    logic commit;
    logic chg;
    logic alarm_n;
    if (!rst_n) begin
      run = 0; last_smp = '0; m_status = '0; m_valid = 0; m_evt_valid = 0;
      m_evt_data = '0; m_cnt = 0; m_ovf = 0; m_alarm = 0;
      return;
    end
    if (run == 0 || data != last_smp) run = 1;
    else if (run <= S) run = run + 1;
    last_smp = data;
    commit = (run == S);
    chg = commit && m_valid && (data != m_status);
    if (!m_valid)               alarm_n = 0;
    else if (m_status >= thr_hi) alarm_n = 1;
    else if (m_status <= thr_lo) alarm_n = 0;
    else                         alarm_n = m_alarm;
    if (chg) begin
      if (m_evt_valid && !ready) m_ovf = 1;
      m_evt_valid = 1;
      m_evt_data = data;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (m_evt_valid && ready) begin
      m_evt_valid = 0;
    end
    if (clr) begin
      m_cnt = 0;
      m_ovf = 0;
    end
    if (commit) begin
      m_status = data;
      m_valid = 1;
    end
    m_alarm = alarm_n;
  endtask

  task automatic step(input logic [7:0] d, input logic rdy, input logic c, input logic rn);
    data = d; ready = rdy; clr = c; rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    chk("status", 32'(status), 32'(m_status));
    chk("status_valid", 32'(status_valid), 32'(m_valid));
    chk("evt_valid", 32'(evt_valid), 32'(m_evt_valid));
    chk("evt_data", 32'(evt_data), 32'(m_evt_data));
    chk("chg_cnt", 32'(chg_cnt), 32'(m_cnt));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    $display("step d=%02h rdy=%0b clr=%0b rst_n=%0b -> status=%02h v=%0b evt=%0b/%02h cnt=%0d ovf=%0b alarm=%0b",
             d, rdy, c, rn, status, status_valid, evt_valid, evt_data, chg_cnt, ovf, alarm);
  endtask

  initial begin
    logic [7:0] vals [4];
    logic [7:0] v;
    int len;
    vals[0] = 8'h10; vals[1] = 8'h50; vals[2] = 8'hC8; vals[3] = 8'h3C;
    thr_hi = 8'hC0; thr_lo = 8'h40;
    data = '0; ready = 0; clr = 0; rst_n = 0;

    // 1: reset and first commit
    step(8'h00, 0, 0, 0);
    step(8'h00, 0, 0, 0);
    chk("rst_valid", 32'(status_valid), 32'h0);
    step(8'h00, 0, 0, 1);
    step(8'h00, 0, 0, 1);
    chk("t1_not_yet", 32'(status_valid), 32'h0);
    step(8'h00, 0, 0, 1);
    chk("t1_valid", 32'(status_valid), 32'h1);
    chk("t1_evt", 32'(evt_valid), 32'h0);
    chk("t1_cnt", 32'(chg_cnt), 32'h0);
    step(8'h00, 0, 0, 1);

    // 2: 00 -> 5A latency
    step(8'h5A, 0, 0, 1);
    step(8'h5A, 0, 0, 1);
    chk("t2_hold_old", 32'(status), 32'h00);
    step(8'h5A, 0, 0, 1);
    chk("t2_status", 32'(status), 32'h5A);
    chk("t2_evt", 32'(evt_data), 32'h5A);
    chk("t2_cnt", 32'(chg_cnt), 32'h1);
    step(8'h5A, 1, 0, 1);
    chk("t2_accepted", 32'(evt_valid), 32'h0);

    // 3: torn code rejected
    repeat (4) step(8'h00, 1, 0, 1);
    step(8'h7F, 1, 0, 1);
    repeat (4) step(8'h00, 1, 0, 1);
    chk("t3_status", 32'(status), 32'h00);
    chk("t3_evt", 32'(evt_valid), 32'h0);
    chk("t3_cnt", 32'(chg_cnt), 32'h2);

    // 4: overwrite vs. accept-and-reload
    repeat (3) step(8'h11, 0, 0, 1);
    repeat (3) step(8'h22, 0, 0, 1);
    chk("t4_data", 32'(evt_data), 32'h22);
    chk("t4_ovf", 32'(ovf), 32'h1);
    chk("t4_sat", 32'(chg_cnt), 32'h3);
    step(8'h22, 0, 1, 1);
    chk("t4_clr_ovf", 32'(ovf), 32'h0);
    step(8'h33, 0, 0, 1);
    step(8'h33, 0, 0, 1);
    step(8'h33, 1, 0, 1);
    chk("t4_reload_valid", 32'(evt_valid), 32'h1);
    chk("t4_reload_data", 32'(evt_data), 32'h33);
    chk("t4_no_ovf", 32'(ovf), 32'h0);

    // 5: hysteresis alarm, then reset while settling
    repeat (4) step(8'hC0, 1, 0, 1);
    chk("t5_set", 32'(alarm), 32'h1);
    repeat (4) step(8'h80, 1, 0, 1);
    chk("t5_hold", 32'(alarm), 32'h1);
    repeat (4) step(8'h40, 1, 0, 1);
    chk("t5_clear", 32'(alarm), 32'h0);
    repeat (4) step(8'hF0, 1, 0, 1);
    step(8'h99, 0, 0, 1);
    step(8'h99, 0, 0, 0);
    chk("t5_rst_status", 32'(status), 32'h0);
    chk("t5_rst_alarm", 32'(alarm), 32'h0);

    // 6: saturation and clear beating a same-cycle change
    repeat (3) step(8'h01, 1, 0, 1);
    repeat (3) step(8'h02, 1, 0, 1);
    repeat (3) step(8'h03, 1, 0, 1);
    repeat (3) step(8'h04, 1, 0, 1);
    repeat (3) step(8'h05, 1, 0, 1);
    chk("t6_sat", 32'(chg_cnt), 32'h3);
    step(8'h06, 1, 0, 1);
    step(8'h06, 1, 0, 1);
    step(8'h06, 1, 1, 1);
    chk("t6_clr_wins", 32'(chg_cnt), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      v = ($urandom_range(0, 4) == 0) ? 8'($urandom) : vals[$urandom_range(0, 3)];
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++)
        step(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 60) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
